// File: rtl/lsu_handshake_unit.sv
// lsu_handshake_unit: load/store unit with a ready-handshaked data-memory port.
// Holds the pipeline through memory wait states, aligns and extends load data,
// and aborts an access that waits longer than TIMEOUT_CYC cycles.
// Optional build macro: LSU_MISALIGN_TRAP_EN (reject misaligned requests with
// err_misalign instead of forcing the address down to the access size).
module lsu_handshake_unit #(
    parameter int XLEN        = 32,
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              CLK,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_store,
    input  logic [2:0]        req_func3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    input  logic [4:0]        req_rd,
    output logic              stall,
    output logic [ADDR_W-1:0] MEM_addr,
    output logic [XLEN-1:0]   MEM_WR_out,
    output logic [2:0]        MEM_type,
    output logic              MEM_rd_en,
    output logic              MEM_wr_en,
    input  logic              MEM_ready,
    input  logic [XLEN-1:0]   MEM_data,
    output logic              wb_valid,
    output logic [4:0]        wb_rd,
    output logic [XLEN-1:0]   wb_data,
    output logic              err_timeout,
    output logic              err_misalign
);

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    localparam int NBYTES   = XLEN / 8;
    localparam int OFF_W    = $clog2(NBYTES);
    localparam int CNT_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam int LAST_CNT = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t            state, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [XLEN-1:0]   wdata_q;
    logic [2:0]        type_q;
    logic              store_q;
    logic [4:0]        rd_q;
    logic [XLEN-1:0]   load_q;
    logic [CNT_W-1:0]  wait_cnt;
    logic              timeout_q;
    logic              misalign_q;

    logic [2:0]        req_f3_n;
    logic [ADDR_W-1:0] lo_mask;
    logic              req_misalign;
    logic [XLEN-1:0]   req_repl;
    logic [XLEN-1:0]   shifted;
    logic [XLEN-1:0]   load_ext;
    logic              to_hit;

    // Normalise func3, derive alignment mask and lane-replicated store data.
    always_comb begin
        req_f3_n = req_func3;
        if (XLEN == 32 && req_func3[1:0] == 2'b11)
            req_f3_n = {req_func3[2], 2'b10};
        case (req_f3_n[1:0])
            2'b00:   lo_mask = ADDR_W'(0);
            2'b01:   lo_mask = ADDR_W'(1);
            2'b10:   lo_mask = ADDR_W'(3);
            default: lo_mask = ADDR_W'(7);
        endcase
        req_misalign = |(req_addr & lo_mask);
        case (req_f3_n[1:0])
            2'b00:   req_repl = {NBYTES{req_wdata[7:0]}};
            2'b01:   req_repl = {(NBYTES / 2){req_wdata[15:0]}};
            2'b10:   req_repl = {(NBYTES / 4){req_wdata[31:0]}};
            default: req_repl = req_wdata;
        endcase
    end

    // Shift the addressed lane down to bit 0 and extend it to XLEN.
    always_comb begin
        shifted = MEM_data >> {addr_q[OFF_W-1:0], 3'b000};
        case (type_q)
            3'b000:  load_ext = XLEN'($signed(shifted[7:0]));
            3'b001:  load_ext = XLEN'($signed(shifted[15:0]));
            3'b010:  load_ext = XLEN'($signed(shifted[31:0]));
            3'b100:  load_ext = XLEN'(shifted[7:0]);
            3'b101:  load_ext = XLEN'(shifted[15:0]);
            3'b110:  load_ext = XLEN'(shifted[31:0]);
            default: load_ext = shifted;
        endcase
        to_hit = (TIMEOUT_CYC != 0) && !MEM_ready && (wait_cnt == CNT_W'(LAST_CNT));
    end

    // State register.
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_d;
    end

    // Next state and handshake/writeback outputs.
    always_comb begin
        state_d      = state;
        stall        = 1'b0;
        MEM_rd_en    = 1'b0;
        MEM_wr_en    = 1'b0;
        wb_valid     = 1'b0;
        wb_rd        = '0;
        wb_data      = '0;
        err_timeout  = 1'b0;
        err_misalign = 1'b0;
        case (state)
            IDLE: begin
                stall = req_valid;
                if (req_valid)
                    state_d = (TRAP_EN && req_misalign) ? RESP : ACCESS;
            end
            ACCESS: begin
                stall     = 1'b1;
                MEM_rd_en = ~store_q;
                MEM_wr_en = store_q;
                if (MEM_ready || to_hit)
                    state_d = RESP;
            end
            RESP: begin
                state_d      = IDLE;
                wb_valid     = ~store_q & ~timeout_q & ~misalign_q;
                wb_rd        = rd_q;
                wb_data      = load_q;
                err_timeout  = timeout_q;
                err_misalign = misalign_q;
            end
            default: state_d = IDLE;
        endcase
    end

    // Request capture, wait counter and load-data capture.
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            type_q     <= '0;
            store_q    <= 1'b0;
            rd_q       <= '0;
            load_q     <= '0;
            wait_cnt   <= '0;
            timeout_q  <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    addr_q     <= TRAP_EN ? req_addr : (req_addr & ~lo_mask);
                    wdata_q    <= req_repl;
                    type_q     <= req_f3_n;
                    store_q    <= req_store;
                    rd_q       <= req_rd;
                    wait_cnt   <= '0;
                    timeout_q  <= 1'b0;
                    misalign_q <= TRAP_EN & req_misalign;
                end
                ACCESS: begin
                    if (MEM_ready)
                        load_q <= load_ext;
                    else if (wait_cnt != '1)
                        wait_cnt <= wait_cnt + 1'b1;
                    timeout_q <= to_hit;
                end
                default: ;
            endcase
        end
    end

    assign MEM_addr   = addr_q;
    assign MEM_WR_out = wdata_q;
    assign MEM_type   = type_q;

endmodule
